// File: rtl/alu_rs_if.sv
// alu_rs_if: issue, result-bus and dispatch bundle of the ALU reservation station.
// slave = station side (takes issue/CDB, drives dispatch); master = issuer/environment side.
interface alu_rs_if #(
    parameter int ROB_SZ_LOG = 3
);
    localparam int TW = ROB_SZ_LOG + 1;

    logic          iss_flg;
    logic [3:0]    iss_opcode;
    logic [3:0]    iss_optype;
    logic [31:0]   iss_Vj;
    logic [31:0]   iss_Vk;
    logic          iss_Qj_wait;
    logic          iss_Qk_wait;
    logic [TW-1:0] iss_Qj;
    logic [TW-1:0] iss_Qk;
    logic [31:0]   iss_imm;
    logic [31:0]   iss_pc;
    logic [TW-1:0] iss_rd;

    logic          alu_cdb_flg;
    logic [TW-1:0] alu_cdb_tag;
    logic [31:0]   alu_cdb_val;
    logic          lsb_cdb_flg;
    logic [TW-1:0] lsb_cdb_tag;
    logic [31:0]   lsb_cdb_val;

    logic          rs_full;
    logic          run_flg;
    logic [TW-1:0] rd_fr;
    logic [31:0]   Vj;
    logic [31:0]   Vk;
    logic [31:0]   imm;
    logic [31:0]   pc;
    logic [3:0]    opcode;
    logic [3:0]    optype;

    modport slave (
        input  iss_flg, iss_opcode, iss_optype, iss_Vj, iss_Vk,
        input  iss_Qj_wait, iss_Qk_wait, iss_Qj, iss_Qk,
        input  iss_imm, iss_pc, iss_rd,
        input  alu_cdb_flg, alu_cdb_tag, alu_cdb_val,
        input  lsb_cdb_flg, lsb_cdb_tag, lsb_cdb_val,
        output rs_full, run_flg, rd_fr, Vj, Vk, imm, pc,
        output opcode, optype
    );

    modport master (
        output iss_flg, iss_opcode, iss_optype, iss_Vj, iss_Vk,
        output iss_Qj_wait, iss_Qk_wait, iss_Qj, iss_Qk,
        output iss_imm, iss_pc, iss_rd,
        output alu_cdb_flg, alu_cdb_tag, alu_cdb_val,
        output lsb_cdb_flg, lsb_cdb_tag, lsb_cdb_val,
        input  rs_full, run_flg, rd_fr, Vj, Vk, imm, pc,
        input  opcode, optype
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: integer-ALU reservation station; buffers issued ops, snoops both CDBs, dispatches one ready op per cycle.
// Ports: clk, rst_n (async low), rdy (global stall), clr (flush), bus (alu_rs_if.slave).
module alu_rs #(
    parameter int RS_SZ      = 8,
    parameter int ROB_SZ_LOG = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rdy,
    input  logic      clr,
    alu_rs_if.slave   bus
);
    localparam int TW = ROB_SZ_LOG + 1;
    localparam int IW = $clog2(RS_SZ);

    typedef struct packed {
        logic [3:0]    opcode;
        logic [3:0]    optype;
        logic [31:0]   vj;
        logic          qj_wait;
        logic [TW-1:0] qj;
        logic [31:0]   vk;
        logic          qk_wait;
        logic [TW-1:0] qk;
        logic [31:0]   imm;
        logic [31:0]   pc;
        logic [TW-1:0] rd;
    } ent_t;

    logic [RS_SZ-1:0] busy;
    ent_t             ent   [RS_SZ];
    ent_t             wake  [RS_SZ];
    ent_t             new_ent;
    logic [RS_SZ-1:0] ready_vec;
    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic             free_vld;
    logic [IW-1:0]    free_idx;

    // Resolve one operand against both buses; ALU bus wins on a double hit.
    function automatic logic [32:0] snoop(
        input logic          w,
        input logic [TW-1:0] q,
        input logic [31:0]   v,
        input logic          af,
        input logic [TW-1:0] at,
        input logic [31:0]   av,
        input logic          lf,
        input logic [TW-1:0] lt,
        input logic [31:0]   lv
    );
        logic [32:0] r;
        r = {w, v};
        if (w && af && at == q)
            r = {1'b0, av};
        else if (w && lf && lt == q)
            r = {1'b0, lv};
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SZ; i++) begin
            wake[i] = ent[i];
            {wake[i].qj_wait, wake[i].vj} = snoop(
                ent[i].qj_wait, ent[i].qj, ent[i].vj,
                bus.alu_cdb_flg, bus.alu_cdb_tag, bus.alu_cdb_val,
                bus.lsb_cdb_flg, bus.lsb_cdb_tag, bus.lsb_cdb_val);
            {wake[i].qk_wait, wake[i].vk} = snoop(
                ent[i].qk_wait, ent[i].qk, ent[i].vk,
                bus.alu_cdb_flg, bus.alu_cdb_tag, bus.alu_cdb_val,
                bus.lsb_cdb_flg, bus.lsb_cdb_tag, bus.lsb_cdb_val);
        end
    end

    always_comb begin
        new_ent.opcode = bus.iss_opcode;
        new_ent.optype = bus.iss_optype;
        new_ent.qj     = bus.iss_Qj;
        new_ent.qk     = bus.iss_Qk;
        new_ent.imm    = bus.iss_imm;
        new_ent.pc     = bus.iss_pc;
        new_ent.rd     = bus.iss_rd;
        {new_ent.qj_wait, new_ent.vj} = snoop(
            bus.iss_Qj_wait, bus.iss_Qj, bus.iss_Vj,
            bus.alu_cdb_flg, bus.alu_cdb_tag, bus.alu_cdb_val,
            bus.lsb_cdb_flg, bus.lsb_cdb_tag, bus.lsb_cdb_val);
        {new_ent.qk_wait, new_ent.vk} = snoop(
            bus.iss_Qk_wait, bus.iss_Qk, bus.iss_Vk,
            bus.alu_cdb_flg, bus.alu_cdb_tag, bus.alu_cdb_val,
            bus.lsb_cdb_flg, bus.lsb_cdb_tag, bus.lsb_cdb_val);
    end

    // Select and free-slot search use stored state only.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            ready_vec[i] = busy[i] & ~ent[i].qj_wait & ~ent[i].qk_wait;
            if (ready_vec[i]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(i);
            end
            if (!busy[i]) begin
                free_vld = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign bus.rs_full = ~free_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            bus.run_flg <= 1'b0;
            bus.rd_fr   <= '0;
            bus.Vj      <= '0;
            bus.Vk      <= '0;
            bus.imm     <= '0;
            bus.pc      <= '0;
            bus.opcode  <= '0;
            bus.optype  <= '0;
            for (int i = 0; i < RS_SZ; i++)
                ent[i] <= '0;
        end else if (!rdy) begin
            bus.run_flg <= 1'b0;
        end else if (clr) begin
            busy        <= '0;
            bus.run_flg <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SZ; i++)
                ent[i] <= wake[i];
            bus.run_flg <= sel_vld;
            if (sel_vld) begin
                busy[sel_idx] <= 1'b0;
                bus.rd_fr     <= ent[sel_idx].rd;
                bus.Vj        <= ent[sel_idx].vj;
                bus.Vk        <= ent[sel_idx].vk;
                bus.imm       <= ent[sel_idx].imm;
                bus.pc        <= ent[sel_idx].pc;
                bus.opcode    <= ent[sel_idx].opcode;
                bus.optype    <= ent[sel_idx].optype;
            end
            // free_idx is never sel_idx: one is busy, the other is not.
            if (bus.iss_flg && free_vld) begin
                busy[free_idx] <= 1'b1;
                ent[free_idx]  <= new_ent;
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus random traffic, scoreboarded against a slot-level model.
// Drives alu_rs through alu_rs_if; prints one summary line.
module tb_alu_rs;
    localparam int RS_SZ = 8;
    localparam int RL    = 3;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] TY_CAL  = 4'h1;
    localparam logic [3:0] TY_CALI = 4'h2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    logic clr   = 1'b0;

    alu_rs_if #(.ROB_SZ_LOG(RL)) bus();

    alu_rs #(.RS_SZ(RS_SZ), .ROB_SZ_LOG(RL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rdy  (rdy),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit         b;
        logic [3:0] op, ty, qj, qk, rd;
        logic [31:0] vj, vk, imm, pc;
        bit         jw, kw;
    } ment_t;

    ment_t        m [RS_SZ];
    logic [139:0] expq [$];

    function automatic int mcount();
        int c = 0;
        foreach (m[i]) if (m[i].b) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // An operand waiting on tag q picks up a matching bus value; ALU bus first.
    function automatic void res(input bit w, input logic [3:0] q, input logic [31:0] v,
                                output bit wo, output logic [31:0] vo);
        wo = w;
        vo = v;
        if (w && bus.alu_cdb_flg && bus.alu_cdb_tag == q) begin
            wo = 1'b0;
            vo = bus.alu_cdb_val;
        end else if (w && bus.lsb_cdb_flg && bus.lsb_cdb_tag == q) begin
            wo = 1'b0;
            vo = bus.lsb_cdb_val;
        end
    endfunction

    // Reference model: slots with readiness, evaluated once per edge.
    always @(posedge clk or negedge rst_n) begin
        int    sel;
        int    fr;
        ment_t n;
        if (!rst_n) begin
            foreach (m[i]) m[i].b = 1'b0;
            expq.delete();
        end else if (rdy) begin
            if (clr) begin
                foreach (m[i]) m[i].b = 1'b0;
            end else begin
                sel = -1;
                fr  = -1;
                for (int i = 0; i < RS_SZ; i++) begin
                    if (sel < 0 && m[i].b && !m[i].jw && !m[i].kw) sel = i;
                    if (fr < 0 && !m[i].b) fr = i;
                end
                if (sel >= 0) begin
                    expq.push_back({m[sel].op, m[sel].ty, m[sel].vj, m[sel].vk,
                                    m[sel].imm, m[sel].pc, m[sel].rd});
                    m[sel].b = 1'b0;
                end
                for (int i = 0; i < RS_SZ; i++) begin
                    if (m[i].b) begin
                        res(m[i].jw, m[i].qj, m[i].vj, m[i].jw, m[i].vj);
                        res(m[i].kw, m[i].qk, m[i].vk, m[i].kw, m[i].vk);
                    end
                end
                if (bus.iss_flg) begin
                    if (fr < 0) begin
                        $display("note: issue while station full, instruction dropped (rd=%0d)", bus.iss_rd);
                    end else begin
                        n.b   = 1'b1;
                        n.op  = bus.iss_opcode;
                        n.ty  = bus.iss_optype;
                        n.qj  = bus.iss_Qj;
                        n.qk  = bus.iss_Qk;
                        n.imm = bus.iss_imm;
                        n.pc  = bus.iss_pc;
                        n.rd  = bus.iss_rd;
                        res(bus.iss_Qj_wait, bus.iss_Qj, bus.iss_Vj, n.jw, n.vj);
                        res(bus.iss_Qk_wait, bus.iss_Qk, bus.iss_Vk, n.kw, n.vk);
                        m[fr] = n;
                    end
                end
            end
        end
    end

    // Monitor: compare every dispatch (or its absence) with the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rs_full", 32'(bus.rs_full), 32'(mcount() == RS_SZ));
            if (bus.run_flg) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dispatch: got rd_fr=%0d expected no dispatch", bus.rd_fr);
                end else begin
                    logic [139:0] e;
                    logic [139:0] a;
                    e = expq.pop_front();
                    a = {bus.opcode, bus.optype, bus.Vj, bus.Vk, bus.imm, bus.pc, bus.rd_fr};
                    vectors++;
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL dispatch: got %0h expected %0h", a, e);
                    end
                end
            end else if (expq.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dispatch: got run_flg=0 expected dispatch %0h", expq.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        bus.iss_flg     = 1'b0;
        bus.alu_cdb_flg = 1'b0;
        bus.lsb_cdb_flg = 1'b0;
        clr             = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] ty,
                         input logic [31:0] vj, input bit jw, input logic [3:0] qj,
                         input logic [31:0] vk, input bit kw, input logic [3:0] qk,
                         input logic [31:0] im, input logic [31:0] pc,
                         input logic [3:0] rd);
        bus.iss_flg     = 1'b1;
        bus.iss_opcode  = op;
        bus.iss_optype  = ty;
        bus.iss_Vj      = vj;
        bus.iss_Qj_wait = jw;
        bus.iss_Qj      = qj;
        bus.iss_Vk      = vk;
        bus.iss_Qk_wait = kw;
        bus.iss_Qk      = qk;
        bus.iss_imm     = im;
        bus.iss_pc      = pc;
        bus.iss_rd      = rd;
    endtask

    task automatic alu(input logic [3:0] t, input logic [31:0] v);
        bus.alu_cdb_flg = 1'b1;
        bus.alu_cdb_tag = t;
        bus.alu_cdb_val = v;
    endtask

    task automatic lsb(input logic [3:0] t, input logic [31:0] v);
        bus.lsb_cdb_flg = 1'b1;
        bus.lsb_cdb_tag = t;
        bus.lsb_cdb_val = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.iss_flg = 1'b0;
        alu(0, 0);
        lsb(0, 0);
        bus.alu_cdb_flg = 1'b0;
        bus.lsb_cdb_flg = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset mid-operation with three entries busy.
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, TY_CAL, 0, 1, 15, 1, 0, 0, 0, 32'h40, 4'(i));
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_flg", 32'(bus.run_flg), 32'd0);
        chk("rst_rs_full", 32'(bus.rs_full), 32'd0);
        chk("rst_rd_fr", 32'(bus.rd_fr), 32'd0);
        chk("rst_vj", bus.Vj, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_ADD, TY_CALI, 5, 0, 0, 0, 0, 0, 7, 32'h100, 2);
        step();
        chk("addi_early", 32'(bus.run_flg), 32'd0);
        step();
        chk("addi_run", 32'(bus.run_flg), 32'd1);
        chk("addi_vj", bus.Vj, 32'd5);
        chk("addi_imm", bus.imm, 32'd7);
        chk("addi_rd", 32'(bus.rd_fr), 32'd2);
        chk("addi_sum", bus.Vj + bus.imm, 32'd12);
        step();

        // Wakeup from the ALU bus.
        issue(OP_ADD, TY_CAL, 0, 1, 3, 10, 0, 0, 0, 32'h104, 1);
        step();
        step();
        alu(3, 32);
        step();
        chk("wake_wait", 32'(bus.run_flg), 32'd0);
        step();
        chk("wake_run", 32'(bus.run_flg), 32'd1);
        chk("wake_vj", bus.Vj, 32'd32);
        chk("wake_vk", bus.Vk, 32'd10);
        step();

        // Issue-time bypass with both buses hitting.
        issue(OP_SUB, TY_CAL, 0, 1, 4, 0, 1, 4, 0, 32'h108, 5);
        lsb(4, 9);
        alu(4, 6);
        step();
        step();
        chk("byp_run", 32'(bus.run_flg), 32'd1);
        chk("byp_vj", bus.Vj, 32'd6);
        chk("byp_vk", bus.Vk, 32'd6);
        step();

        // Fill, priority, and drop while full.
        for (int i = 0; i < RS_SZ; i++) begin
            issue(OP_ADD, TY_CAL, 0, 1, 4'(8 + i), 32'(i), 0, 0, 0, 32'h200, 4'(i));
            step();
        end
        chk("full", 32'(bus.rs_full), 32'd1);
        issue(OP_ADD, TY_CAL, 1, 0, 0, 1, 0, 0, 0, 32'h300, 15);
        step();
        chk("full_drop_hold", 32'(bus.rs_full), 32'd1);
        alu(13, 32'h55);
        lsb(10, 32'h22);
        step();
        chk("prio_wake", 32'(bus.run_flg), 32'd0);
        step();
        chk("prio_first", 32'(bus.rd_fr), 32'd2);
        chk("prio_first_vj", bus.Vj, 32'h22);
        chk("full_drop", 32'(bus.rs_full), 32'd0);
        step();
        chk("prio_second", 32'(bus.rd_fr), 32'd5);
        step();
        chk("dropped_absent", 32'(bus.run_flg), 32'd0);
        clr = 1'b1;
        step();
        chk("clr_empty", 32'(bus.rs_full), 32'd0);

        // Flush with a ready entry and a same-cycle issue.
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, TY_CAL, 0, 1, 9, 0, 0, 0, 0, 32'h400, 4'(i));
            step();
        end
        issue(OP_ADD, TY_CAL, 3, 0, 0, 4, 0, 0, 0, 32'h404, 7);
        step();
        clr = 1'b1;
        issue(OP_ADD, TY_CAL, 3, 0, 0, 4, 0, 0, 0, 32'h408, 8);
        step();
        chk("flush_run", 32'(bus.run_flg), 32'd0);
        chk("flush_full", 32'(bus.rs_full), 32'd0);
        step();
        chk("flush_discard", 32'(bus.run_flg), 32'd0);

        // Stall with a ready entry and a bus broadcast.
        issue(OP_ADD, TY_CAL, 0, 1, 6, 1, 0, 0, 0, 32'h500, 3);
        step();
        issue(OP_SUB, TY_CAL, 9, 0, 0, 2, 0, 0, 0, 32'h504, 4);
        step();
        rdy = 1'b0;
        alu(6, 77);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_run", 32'(bus.run_flg), 32'd0);
        end
        rdy = 1'b1;
        step();
        chk("stall_resume", 32'(bus.rd_fr), 32'd4);
        step();
        chk("stall_nocap", 32'(bus.run_flg), 32'd0);
        alu(6, 88);
        step();
        step();
        chk("stall_late_vj", bus.Vj, 32'd88);
        chk("stall_late_rd", 32'(bus.rd_fr), 32'd3);
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom % 10) != 0;
            clr = ($urandom % 150) == 0;
            if (mcount() < RS_SZ && ($urandom % 2) == 1)
                issue(4'($urandom), 4'($urandom), $urandom, 1'($urandom),
                      4'($urandom), $urandom, 1'($urandom), 4'($urandom),
                      $urandom, $urandom, 4'($urandom));
            if ($urandom % 2) alu(4'($urandom), $urandom);
            if ($urandom % 2) lsb(4'($urandom), $urandom);
            step();
        end

        // Drain every waiting entry.
        rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            alu(4'(c), $urandom);
            lsb(4'(c + 8), $urandom);
            step();
        end
        repeat (RS_SZ + 2) step();
        chk("drain_full", 32'(bus.rs_full), 32'd0);
        chk("drain_run", 32'(bus.run_flg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU in the Tomasulo out-of-order core. It buffers decoded CAL/CALi/BRA/JUM instructions from the issue stage and tracks operand readiness by ROB tag. It captures operand values broadcast on the two result buses (ALU and load/store). Each cycle it dispatches at most one ready instruction to the combinational ALU through a registered output bundle.

## Interface
- `RS_SZ`, 8: number of entries, a power of two from 2 to 16.
- `ROB_SZ_LOG`, 3: ROB tags are `ROB_SZ_LOG+1` bits wide.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global ready. When low, the block freezes.
- `clr` in 1: flush after a branch mispredict, synchronous.
- `iss_flg` in 1: issue a new instruction this cycle.
- `iss_opcode`, `iss_optype` in 4 each: operation fields as encoded in `def.v`.
- `iss_Vj`, `iss_Vk` in 32 each: operand values, meaningful when the matching wait flag is 0.
- `iss_Qj_wait`, `iss_Qk_wait` in 1 each: operand still pending.
- `iss_Qj`, `iss_Qk` in `ROB_SZ_LOG+1` each: producer tag of each pending operand.
- `iss_imm`, `iss_pc` in 32 each: immediate value and instruction PC.
- `iss_rd` in `ROB_SZ_LOG+1`: ROB tag of the instruction being issued.
- `alu_cdb_flg`, `alu_cdb_tag`, `alu_cdb_val` in 1 / `ROB_SZ_LOG+1` / 32: ALU result bus.
- `lsb_cdb_flg`, `lsb_cdb_tag`, `lsb_cdb_val` in 1 / `ROB_SZ_LOG+1` / 32: load/store result bus.
- `rs_full` out 1: all entries occupied. Combinational from registered state.
- `run_flg` out 1: dispatch valid, registered.
- `rd_fr` out `ROB_SZ_LOG+1`: ROB tag of the dispatched instruction.
- `Vj`, `Vk`, `imm`, `pc` out 32 each: operands of the dispatched instruction.
- `opcode`, `optype` out 4 each: operation of the dispatched instruction.

## Operation
- **Entry contents:** busy, opcode, optype, Vj, Qj_wait, Qj, Vk, Qk_wait, Qk, imm, pc, rd.
- **Ready condition:** an entry is ready when it is busy and both Qj_wait and Qk_wait are 0.
- **Issue:**
  - When `iss_flg` is high and `rs_full` is low, the lowest-index non-busy entry is written.
  - If `iss_flg` is high while `rs_full` is high, the instruction is dropped. This is an issuer protocol violation; the bench flags it.
- **Issue-time bypass:** when an incoming operand is waiting and its tag matches a CDB valid this cycle, the entry stores the CDB value with wait=0. If both CDBs match, the ALU CDB wins.
- **Wakeup:** every busy entry whose waiting Qj/Qk matches a valid CDB tag captures that value and clears its wait flag at the edge. Both operands may wake on the same edge, from the same bus or different buses.
- **Select:**
  - Select looks at stored state only. A priority encoder picks the lowest-index ready entry.
  - At the edge, the selected entry's fields are loaded into the outputs, `run_flg` is set to 1, and the entry's busy bit is cleared.
  - If no entry is ready, `run_flg` is set to 0 and the data outputs hold their previous values.
- **Same-cycle issue and dispatch:** both are allowed. The freed slot becomes reusable on the next cycle only.
- **`clr`:** has priority over issue, wakeup and dispatch. At the edge, all busy bits clear and `run_flg` goes to 0.
- **`rdy` low:** entries are frozen, with no issue, wakeup or dispatch, and `run_flg` is registered as 0. CDB broadcasts during `rdy` low are not captured. The upstream stages also stall on `rdy`.
- **Reset (`rst_n` low):** all busy bits = 0; `run_flg` = 0; `rd_fr`, `Vj`, `Vk`, `imm`, `pc`, `opcode`, `optype` = 0; `rs_full` = 0.

## Timing
- **Minimum issue-to-dispatch latency:** `iss_flg` is sampled at edge E0 with both operands ready. The entry is selected during the following cycle and dispatched at E1. `run_flg` is high between E1 and E2.
- **Wakeup latency:** a CDB broadcast at edge Ew makes the entry ready after Ew. The earliest dispatch is Ew+1.
- **Bypass latency:** with issue-time bypass, the instruction behaves as if its operands were ready at issue, giving dispatch at E1.
- **`run_flg` pulse:** `run_flg` is high for exactly one cycle per dispatched instruction. Back-to-back dispatch is allowed every cycle.
- **`rs_full` timing:** `rs_full` reflects the busy bits after the last edge. A dispatch in the current cycle does not lower it until the next edge.
- **Reset timing:** reset is asynchronous on assertion. All outputs take their reset values immediately, independent of `clk`.

## Test plan
- **Reset:** hold `rst_n`=0 mid-operation with 3 entries busy, then release. Required: `run_flg`=0 and `rs_full`=0. Issuing ADDI with Vj=5, imm=7, rd=2 then gives `run_flg`=1 one cycle later with Vj=5, imm=7, rd_fr=2, and the ALU produces 12.
- **Wakeup:** issue ADD rd=1 waiting on Qj=3 with Vk=10. Broadcast alu_cdb tag 3, value 32 two cycles later. Required: dispatch on the next edge with Vj=32, Vk=10.
- **Bypass and bus priority:** issue SUB with Qj=4 and Qk=4 waiting, in the same cycle as lsb_cdb tag 4 value 9 and alu_cdb tag 4 value 6. Required: dispatch at E1 with Vj=Vk=6, because the ALU CDB wins.
- **Full and priority:**
  - Fill all 8 entries with non-ready instructions. Required: `rs_full`=1.
  - Wake entries 5 and 2 on the same edge. Required: entry 2 dispatches first, then entry 5. `rs_full` drops one cycle after the first dispatch.
  - Issue with `iss_flg` while full. Required: the instruction is not stored.
- **Flush:** fill 4 entries, then pulse `clr` together with `iss_flg` and a ready entry. Required: no dispatch, `run_flg`=0, `rs_full`=0, and the instruction issued in the `clr` cycle is discarded.
- **Stall:** hold `rdy`=0 for 3 cycles with a ready entry and a CDB broadcast. Required: `run_flg` stays 0 and the broadcast value is not captured. After `rdy` returns high, the ready entry dispatches one cycle later.
